// File: rtl/spi_shift_engine_if.sv
// Bus between the SPI shift engine and its surroundings: the clock generator
// strobes, the host-side word/configuration inputs and the serial pins.
interface spi_shift_engine_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 5
);
   logic              go;
   logic              pos_edge;
   logic              neg_edge;
   logic              s_clk;
   logic [LEN_W-1:0]  len;
   logic              lsb;
   logic              tx_negedge;
   logic              rx_negedge;
   logic [DATA_W-1:0] tx_data;
   logic              s_miso;
   logic              tip;
   logic              last;
   logic              s_mosi;
   logic [DATA_W-1:0] rx_data;
   logic              done;

   // Host / generator / slave side
   modport master (
      output go, pos_edge, neg_edge, s_clk, len, lsb, tx_negedge, rx_negedge,
             tx_data, s_miso,
      input  tip, last, s_mosi, rx_data, done
   );

   // Shift engine side
   modport slave (
      input  go, pos_edge, neg_edge, s_clk, len, lsb, tx_negedge, rx_negedge,
             tx_data, s_miso,
      output tip, last, s_mosi, rx_data, done
   );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI shift engine: shifts a 1..DATA_W bit word out on s_mosi and captures the
// same number of bits from s_miso, driving the clock generator's enable (tip)
// and last_clk (last).
// Optional build macro SPI_SHIFT_LOOPBACK_EN: when defined, the receive path
// captures the internal s_mosi register instead of the s_miso pin.
module spi_shift_engine #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 5
) (
   input logic               clk_in,
   input logic               rst,
   spi_shift_engine_if.slave bus
);

   localparam int unsigned CNT_W = LEN_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t            state_q, state_d;

   logic [DATA_W-1:0] tx_reg_q, tx_reg_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic              lsb_q, lsb_d;
   logic              txneg_q, txneg_d;
   logic              rxneg_q, rxneg_d;
   logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic              tip_q, tip_d;
   logic              last_q, last_d;
   logic              mosi_q, mosi_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              done_q, done_d;

   logic [CNT_W-1:0]  total_in_c;
   logic              tx_stb_c;
   logic              rx_stb_c;
   logic              tx_fire_c;
   logic              rx_fire_c;
   logic [CNT_W-1:0]  rx_cnt_inc_c;
   logic              rx_last_c;
   logic              rx_bit_c;

   // Wire position k maps to word bit k (LSB first) or total-1-k (MSB first)
   function automatic logic [LEN_W-1:0] bit_idx(
      input logic [CNT_W-1:0] k,
      input logic [CNT_W-1:0] tot,
      input logic             lsb_first
   );
      return LEN_W'(lsb_first ? k : (tot - k - CNT_W'(1)));
   endfunction

   // Transfer length decode: len of zero selects a full-width word
   always_comb begin
      total_in_c = (bus.len == '0) ? CNT_W'(DATA_W) : CNT_W'(bus.len);
   end

   // Strobe selection and shift qualification (only meaningful in SHIFT)
   always_comb begin
      tx_stb_c     = txneg_q ? bus.neg_edge : bus.pos_edge;
      rx_stb_c     = rxneg_q ? bus.neg_edge : bus.pos_edge;
      tx_fire_c    = (state_q == SHIFT) && tx_stb_c && (tx_cnt_q < total_q);
      rx_fire_c    = (state_q == SHIFT) && rx_stb_c && (rx_cnt_q < total_q);
      rx_cnt_inc_c = rx_cnt_q + CNT_W'(1);
      rx_last_c    = rx_fire_c && (rx_cnt_inc_c == total_q);
   end

   // Receive bit source: external pin, or the launched bit in loopback builds
`ifdef SPI_SHIFT_LOOPBACK_EN
   always_comb begin
      rx_bit_c = mosi_q;
   end
`else
   always_comb begin
      rx_bit_c = bus.s_miso;
   end
`endif

   // State register
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.go) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (rx_last_c) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            if (!bus.s_clk) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      tx_reg_d  = tx_reg_q;
      rx_sr_d   = rx_sr_q;
      total_d   = total_q;
      lsb_d     = lsb_q;
      txneg_d   = txneg_q;
      rxneg_d   = rxneg_q;
      tx_cnt_d  = tx_cnt_q;
      rx_cnt_d  = rx_cnt_q;
      tip_d     = tip_q;
      last_d    = last_q;
      mosi_d    = mosi_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.go) begin
               tx_reg_d = bus.tx_data;
               rx_sr_d  = '0;
               total_d  = total_in_c;
               lsb_d    = bus.lsb;
               txneg_d  = bus.tx_negedge;
               rxneg_d  = bus.rx_negedge;
               // First bit is presented before any serial clock edge
               mosi_d   = bus.tx_data[bit_idx(CNT_W'(0), total_in_c, bus.lsb)];
               tx_cnt_d = CNT_W'(1);
               rx_cnt_d = '0;
               tip_d    = 1'b1;
               last_d   = 1'b0;
            end
         end
         SHIFT: begin
            if (tx_fire_c) begin
               mosi_d   = tx_reg_q[bit_idx(tx_cnt_q, total_q, lsb_q)];
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
            if (rx_fire_c) begin
               rx_sr_d[bit_idx(rx_cnt_q, total_q, lsb_q)] = rx_bit_c;
               rx_cnt_d = rx_cnt_inc_c;
            end
            // Hold the generator's clock low once every bit is in
            if (rx_last_c) begin
               last_d = 1'b1;
            end
         end
         FINISH: begin
            if (!bus.s_clk) begin
               rx_data_d = rx_sr_q;
               tip_d     = 1'b0;
               last_d    = 1'b0;
               done_d    = 1'b1;
            end
         end
         default: begin
            tip_d  = 1'b0;
            last_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         tx_reg_q  <= '0;
         rx_sr_q   <= '0;
         total_q   <= '0;
         lsb_q     <= 1'b0;
         txneg_q   <= 1'b0;
         rxneg_q   <= 1'b0;
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
         tip_q     <= 1'b0;
         last_q    <= 1'b0;
         mosi_q    <= 1'b0;
         rx_data_q <= '0;
         done_q    <= 1'b0;
      end else begin
         tx_reg_q  <= tx_reg_d;
         rx_sr_q   <= rx_sr_d;
         total_q   <= total_d;
         lsb_q     <= lsb_d;
         txneg_q   <= txneg_d;
         rxneg_q   <= rxneg_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         tip_q     <= tip_d;
         last_q    <= last_d;
         mosi_q    <= mosi_d;
         rx_data_q <= rx_data_d;
         done_q    <= done_d;
      end
   end

   // Output drive
   always_comb begin
      bus.tip     = tip_q;
      bus.last    = last_q;
      bus.s_mosi  = mosi_q;
      bus.rx_data = rx_data_q;
      bus.done    = done_q;
   end

endmodule
